// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per clock.
// Latency: BIN_W cycles from the accepting edge to the one-cycle done pulse.
// Backpressure: start is only sampled in IDLE; start while busy is ignored.
// Optional macro BIN2BCD_SIGNED_EN: two's-complement input, magnitude converted, sign on neg.
module bin2bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  neg
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [BIN_W-1:0]   sh;
  logic [BCD_W-1:0]   dig;
  logic [BCD_W-1:0]   dig_corr;
  logic [BCD_W-1:0]   dig_shifted;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_acc;
  logic               ovf_step;
  logic               accept;
  logic               last;
  logic [BIN_W-1:0]   load_val;

`ifdef BIN2BCD_SIGNED_EN
  logic               load_sign;
  logic               sign_r;

  // Latch the magnitude; the most negative value maps to 2^(BIN_W-1), which still fits unsigned.
  always_comb begin
    load_sign = bin_in[BIN_W-1];
    load_val  = load_sign ? (~bin_in + BIN_W'(1)) : bin_in;
  end
`else
  // Unsigned build: the input is converted as-is.
  always_comb begin
    load_val = bin_in;
  end
`endif

  // Handshake qualifiers: acceptance in IDLE, last step when one bit remains.
  always_comb begin
    accept = (state == IDLE) && start;
    last   = (state == SHIFT) && (cnt == CNT_W'(1));
  end

  // Add-3 correction on every digit in parallel, then the one-bit left shift into digit 0.
  always_comb begin
    dig_corr = dig;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig[4*i +: 4] >= 4'd5) begin
        dig_corr[4*i +: 4] = dig[4*i +: 4] + 4'd3;
      end
    end
    dig_shifted = {dig_corr[BCD_W-2:0], sh[BIN_W-1]};
    ovf_step    = dig_corr[BCD_W-1];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE waits for start, SHIFT runs until the last bit is consumed.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SHIFT);

  // Datapath: load on accept, shift each SHIFT cycle, publish results on the last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh      <= '0;
      dig     <= '0;
      cnt     <= '0;
      ovf_acc <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        sh      <= load_val;
        dig     <= '0;
        cnt     <= CNT_W'(BIN_W);
        ovf_acc <= 1'b0;
      end else if (state == SHIFT) begin
        sh      <= {sh[BIN_W-2:0], 1'b0};
        dig     <= dig_shifted;
        ovf_acc <= ovf_acc | ovf_step;
        cnt     <= cnt - CNT_W'(1);
        if (last) begin
          bcd_out <= dig_shifted;
          ovf     <= ovf_acc | ovf_step;
          done    <= 1'b1;
        end
      end
    end
  end

`ifdef BIN2BCD_SIGNED_EN
  // Sign captured at acceptance, presented together with the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r <= 1'b0;
      neg    <= 1'b0;
    end else begin
      if (accept) begin
        sign_r <= load_sign;
      end
      if (last) begin
        neg <= sign_r;
      end
    end
  end
`else
  assign neg = 1'b0;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: directed table, handshake corner cases, randomized values vs. model.
module tb_bin2bcd_seq;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 3;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [BIN_W-1:0]    bin_in;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic                ovf;
  logic                neg;

  int checks = 0;
  int errors = 0;

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf),
    .neg     (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BIN_W-1:0]    bin;
    logic [4*DIGITS-1:0] bcd;
    logic                o;
    logic                n;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits of the magnitude by plain division.
  function automatic void model(input logic [BIN_W-1:0] v, output logic [4*DIGITS-1:0] bcd,
                                output logic o, output logic n);
    int mag;
    int p;
    mag = int'(v);
    n   = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (v[BIN_W-1]) begin
      mag = (1 << BIN_W) - int'(v);
      n   = 1'b1;
    end
`endif
    p = 1;
    for (int d = 0; d < DIGITS; d++) begin
      bcd[4*d +: 4] = 4'((mag / p) % 10);
      p = p * 10;
    end
    o = (mag >= p);
  endfunction

  // Advance edge by edge (sampling 1 time unit after) until done; counts edges and busy cycles.
  task automatic wait_done(output int lat, inout int busy_cnt);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (busy && !done) busy_cnt++;
    end while (!done && lat < 40);
    if (!done) begin
      errors++;
      checks++;
      $display("FAIL wait_done: timeout after %0d cycles, done=%0b", lat, done);
    end
  endtask

  // One full conversion with latency, busy-width and result checks.
  task automatic run_conv(input logic [BIN_W-1:0] v, input logic [4*DIGITS-1:0] e_bcd,
                          input logic e_o, input logic e_n, input string name);
    int lat;
    int bc;
    start  = 1'b1;
    bin_in = v;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bin_in = BIN_W'($urandom);
    bc = busy ? 1 : 0;
    wait_done(lat, bc);
    check({name, " latency"}, lat, BIN_W);
    check({name, " busy_cycles"}, bc, BIN_W);
    check({name, " bcd"}, bcd_out, e_bcd);
    check({name, " ovf"}, ovf, e_o);
    check({name, " neg"}, neg, e_n);
    @(posedge clk);
    #1;
    check({name, " done_low"}, done, 1'b0);
  endtask

  vec_t tbl[$];

  initial begin
    int lat;
    int bc;
    int n_done;
    int n_busy;
    logic [BIN_W-1:0]    rv;
    logic [4*DIGITS-1:0] m_bcd;
    logic                m_o;
    logic                m_n;

`ifdef BIN2BCD_SIGNED_EN
    tbl.push_back('{10'd0,   12'h000, 1'b0, 1'b0});
    tbl.push_back('{10'h200, 12'h512, 1'b0, 1'b1});
    tbl.push_back('{10'h3FF, 12'h001, 1'b0, 1'b1});
    tbl.push_back('{10'd255, 12'h255, 1'b0, 1'b0});
    tbl.push_back('{10'd511, 12'h511, 1'b0, 1'b0});
    tbl.push_back('{10'd7,   12'h007, 1'b0, 1'b0});
`else
    tbl.push_back('{10'd0,    12'h000, 1'b0, 1'b0});
    tbl.push_back('{10'd255,  12'h255, 1'b0, 1'b0});
    tbl.push_back('{10'd999,  12'h999, 1'b0, 1'b0});
    tbl.push_back('{10'd1023, 12'h023, 1'b1, 1'b0});
    tbl.push_back('{10'd7,    12'h007, 1'b0, 1'b0});
    tbl.push_back('{10'd1000, 12'h000, 1'b1, 1'b0});
    tbl.push_back('{10'd512,  12'h512, 1'b0, 1'b0});
`endif

    rst_n  = 1'b0;
    start  = 1'b0;
    bin_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset bcd", bcd_out, '0);
    check("reset ovf", ovf, 1'b0);
    check("reset neg", neg, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed table.
    for (int i = 0; i < tbl.size(); i++) begin
      run_conv(tbl[i].bin, tbl[i].bcd, tbl[i].o, tbl[i].n, $sformatf("vec%0d", i));
    end

    // start pulsed mid-conversion must be ignored.
    start  = 1'b1;
    bin_in = 10'd500;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    start  = 1'b1;
    bin_in = 10'd77;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("midstart done_count", n_done, 1);
    check("midstart bcd", bcd_out, 12'h500);

    // start held through the done cycle: back-to-back conversion.
    start  = 1'b1;
    bin_in = 10'd500;
    @(posedge clk);
    #1;
    bin_in = 10'd77;
    bc = 0;
    wait_done(lat, bc);
    check("hold first latency", lat, BIN_W);
    check("hold first bcd", bcd_out, 12'h500);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("hold accepted busy", busy, 1'b1);
    wait_done(lat, bc);
    check("hold done gap", lat + 1, BIN_W + 1);
    check("hold second bcd", bcd_out, 12'h077);

    // Reset mid-conversion aborts with no done pulse.
    start  = 1'b1;
    bin_in = 10'd123;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort done", done, 1'b0);
    check("abort bcd", bcd_out, '0);
    check("abort ovf", ovf, 1'b0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    n_done = 0;
    n_busy = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("abort no_done", n_done, 0);
    check("abort stays_idle", n_busy, 0);

    // Randomized values against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rv = BIN_W'($urandom);
      if (i == 0) rv = '1;
      model(rv, m_bcd, m_o, m_n);
      run_conv(rv, m_bcd, m_o, m_n, $sformatf("rand%0d_%0d", i, rv));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
